// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Brief    : Pipeline-side bundle for the hazard/control unit: ID/EX hazard
//            operands, branch resolution, fetch/memory wait flags, and the
//            per-stage flush_and_stall codes plus PC control.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic [4:0]            id_rs1_addr;
  logic [4:0]            id_rs2_addr;
  logic                  ex_mem_read;
  logic [4:0]            ex_rd_addr;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  if_busy;
  logic                  mem_busy;

  logic                  pc_stall;
  logic                  pc_redirect;
  logic [ADDR_WIDTH-1:0] pc_redirect_addr;
  logic [1:0]            ifid_fs;
  logic [1:0]            idex_fs;
  logic [1:0]            exmem_fs;
  logic [1:0]            memwb_fs;
  logic                  discard_active;
  logic [CNT_WIDTH-1:0]  stall_cycles;

  // Pipeline side: supplies hazard inputs, consumes control codes
  modport master (
    output id_rs1_addr, id_rs2_addr, ex_mem_read, ex_rd_addr,
           branch_taken, branch_target, if_busy, mem_busy,
    input  pc_stall, pc_redirect, pc_redirect_addr, ifid_fs, idex_fs,
           exmem_fs, memwb_fs, discard_active, stall_cycles
  );

  // Hazard unit side
  modport slave (
    input  id_rs1_addr, id_rs2_addr, ex_mem_read, ex_rd_addr,
           branch_taken, branch_target, if_busy, mem_busy,
    output pc_stall, pc_redirect, pc_redirect_addr, ifid_fs, idex_fs,
           exmem_fs, memwb_fs, discard_active, stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Hazard and control unit for the 5-stage RISC-V pipeline. Emits
//            flush_and_stall codes (bit0 = hold, bit1 = bubble) per pipeline
//            register, handles load-use, taken-branch redirect and memory
//            wait, parks a redirect while a wrong-path fetch drains, and
//            keeps a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    CNT_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
  input  wire logic     clk,
  input  wire logic     reset,
  hazard_ctrl_if.slave  bus
);

  localparam logic [1:0]           c_fs_none  = 2'b00;
  localparam logic [1:0]           c_fs_stall = 2'b01;
  localparam logic [1:0]           c_fs_flush = 2'b10;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_tgt_q;
  logic [CNT_WIDTH-1:0]  r_stall_cycles;

  logic                  w_load_use;
  logic                  w_load_tgt;
  logic                  w_pc_stall;
  logic                  w_pc_redirect;
  logic [ADDR_WIDTH-1:0] w_redirect_addr;
  logic [1:0]            w_ifid_fs;
  logic [1:0]            w_idex_fs;
  logic [1:0]            w_exmem_fs;
  logic [1:0]            w_memwb_fs;
  logic                  w_discard;

  // x0 is never a real dependency, so a load targeting it cannot cause a hazard
  assign w_load_use = bus.ex_mem_read && (bus.ex_rd_addr != 5'd0) &&
                      ((bus.ex_rd_addr == bus.id_rs1_addr) ||
                       (bus.ex_rd_addr == bus.id_rs2_addr));

  // State register and parked redirect target
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_tgt_q <= PC_ADDR;
    end else begin
      r_state <= w_next_state;
      if (w_load_tgt) begin
        r_tgt_q <= bus.branch_target;
      end
    end
  end

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_pc_stall && (r_stall_cycles != {CNT_WIDTH{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + c_cnt_one;
    end
  end

  // Priority decode of hazards into PC control and per-stage codes
  always_comb begin
    w_next_state    = r_state;
    w_load_tgt      = 1'b0;
    w_pc_stall      = 1'b0;
    w_pc_redirect   = 1'b0;
    w_redirect_addr = bus.branch_target;
    w_ifid_fs       = c_fs_none;
    w_idex_fs       = c_fs_none;
    w_exmem_fs      = c_fs_none;
    w_memwb_fs      = c_fs_none;
    w_discard       = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (bus.mem_busy) begin
          // Freeze everything upstream of MEM; a pending branch stays in EX
          w_pc_stall = 1'b1;
          w_ifid_fs  = c_fs_stall;
          w_idex_fs  = c_fs_stall;
          w_exmem_fs = c_fs_stall;
          w_memwb_fs = c_fs_flush;
        end else if (bus.branch_taken && !bus.if_busy) begin
          w_pc_redirect = 1'b1;
          w_ifid_fs     = c_fs_flush;
          w_idex_fs     = c_fs_flush;
        end else if (bus.branch_taken) begin
          // Fetch still in flight: park the target and drop the wrong-path word later
          w_pc_stall   = 1'b1;
          w_ifid_fs    = c_fs_flush;
          w_idex_fs    = c_fs_flush;
          w_load_tgt   = 1'b1;
          w_next_state = ST_DISCARD;
        end else if (bus.if_busy) begin
          w_pc_stall = 1'b1;
          w_ifid_fs  = c_fs_flush;
        end else if (w_load_use) begin
          w_pc_stall = 1'b1;
          w_ifid_fs  = c_fs_stall;
          w_idex_fs  = c_fs_flush;
        end
      end

      ST_DISCARD: begin
        // ID only ever sees a bubble here, so load-use cannot apply
        w_discard       = 1'b1;
        w_redirect_addr = r_tgt_q;
        w_ifid_fs       = c_fs_flush;
        if (bus.mem_busy) begin
          w_pc_stall = 1'b1;
          w_idex_fs  = c_fs_stall;
          w_exmem_fs = c_fs_stall;
          w_memwb_fs = c_fs_flush;
        end else if (bus.if_busy) begin
          w_pc_stall = 1'b1;
        end else begin
          w_pc_redirect = 1'b1;
          w_next_state  = ST_RUN;
        end
      end

      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  assign bus.pc_stall         = w_pc_stall;
  assign bus.pc_redirect      = w_pc_redirect;
  assign bus.pc_redirect_addr = w_redirect_addr;
  assign bus.ifid_fs          = w_ifid_fs;
  assign bus.idex_fs          = w_idex_fs;
  assign bus.exmem_fs         = w_exmem_fs;
  assign bus.memwb_fs         = w_memwb_fs;
  assign bus.discard_active   = w_discard;
  assign bus.stall_cycles     = r_stall_cycles;

  // EX holds a bubble while draining, so a taken branch there means upstream misbehaved
  a_no_branch_in_discard: assert property (
    @(posedge clk) disable iff (reset) (r_state == ST_DISCARD) |-> !bus.branch_taken
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Scoreboard bench for hazard_ctrl (4-bit stall counter instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam logic [31:0] c_pc_addr = 32'h8000_0000;

  logic clk;
  logic reset;

  hazard_ctrl_if #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) hif ();

  hazard_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(4), .PC_ADDR(c_pc_addr)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] addr;
    logic [1:0]  ifid;
    logic [1:0]  idex;
    logic [1:0]  exmem;
    logic [1:0]  memwb;
    logic        disc;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference state
  logic        m_disc;
  logic [31:0] m_tgt;
  logic [3:0]  m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    logic lu;
    e       = '0;
    e.disc  = m_disc;
    e.cnt   = m_cnt;
    lu = hif.ex_mem_read && (hif.ex_rd_addr != 5'd0) &&
         ((hif.ex_rd_addr == hif.id_rs1_addr) || (hif.ex_rd_addr == hif.id_rs2_addr));
    if (!m_disc) begin
      e.addr = hif.branch_target;
      if (hif.mem_busy) begin
        e.stall = 1'b1; e.ifid = 2'b01; e.idex = 2'b01; e.exmem = 2'b01; e.memwb = 2'b10;
      end else if (hif.branch_taken && !hif.if_busy) begin
        e.redir = 1'b1; e.ifid = 2'b10; e.idex = 2'b10;
      end else if (hif.branch_taken) begin
        e.stall = 1'b1; e.ifid = 2'b10; e.idex = 2'b10;
      end else if (hif.if_busy) begin
        e.stall = 1'b1; e.ifid = 2'b10;
      end else if (lu) begin
        e.stall = 1'b1; e.ifid = 2'b01; e.idex = 2'b10;
      end
    end else begin
      e.addr = m_tgt;
      e.ifid = 2'b10;
      if (hif.mem_busy) begin
        e.stall = 1'b1; e.idex = 2'b01; e.exmem = 2'b01; e.memwb = 2'b10;
      end else if (hif.if_busy) begin
        e.stall = 1'b1;
      end else begin
        e.redir = 1'b1;
      end
    end
    return e;
  endfunction

  // Pop the oldest expectation and compare it against the live outputs
  task automatic sb_compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val({tag, ".sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check_val({tag, ".stall"}, 32'(hif.pc_stall),         32'(e.stall));
    check_val({tag, ".redir"}, 32'(hif.pc_redirect),      32'(e.redir));
    check_val({tag, ".addr"},  hif.pc_redirect_addr,      e.addr);
    check_val({tag, ".ifid"},  32'(hif.ifid_fs),          32'(e.ifid));
    check_val({tag, ".idex"},  32'(hif.idex_fs),          32'(e.idex));
    check_val({tag, ".exmem"}, 32'(hif.exmem_fs),         32'(e.exmem));
    check_val({tag, ".memwb"}, 32'(hif.memwb_fs),         32'(e.memwb));
    check_val({tag, ".disc"},  32'(hif.discard_active),   32'(e.disc));
    check_val({tag, ".cnt"},   32'(hif.stall_cycles),     32'(e.cnt));
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic br, input logic [31:0] tgt,
                       input logic ifb, input logic memb);
    hif.ex_mem_read   = mr;
    hif.ex_rd_addr    = rd;
    hif.id_rs1_addr   = rs1;
    hif.id_rs2_addr   = rs2;
    hif.branch_taken  = br;
    hif.branch_target = tgt;
    hif.if_busy       = ifb;
    hif.mem_busy      = memb;
  endtask

  // One pipeline cycle: drive on negedge, score before posedge, advance reference
  task automatic cycle(input string tag, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                       input logic [31:0] tgt, input logic ifb, input logic memb);
    exp_t e;
    @(negedge clk);
    drive(mr, rd, rs1, rs2, br, tgt, ifb, memb);
    e = model();
    sb_q.push_back(e);
    #2;
    sb_compare(tag);
    if (!m_disc && !memb && br && ifb) begin
      m_disc = 1'b1;
      m_tgt  = tgt;
    end else if (m_disc && !memb && !ifb) begin
      m_disc = 1'b0;
    end
    if (e.stall && (m_cnt != 4'hF)) m_cnt = m_cnt + 4'd1;
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset applied mid-cycle with the current inputs still applied
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #1;
    reset  = 1'b1;
    m_disc = 1'b0;
    m_tgt  = c_pc_addr;
    m_cnt  = 4'd0;
    #1;
    sb_q.push_back(model());
    sb_compare(tag);
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    m_disc = 1'b0; m_tgt = c_pc_addr; m_cnt = 4'd0;
    #12;
    sb_q.push_back(model());
    sb_compare("reset");
    @(negedge clk);
    reset = 1'b0;

    // Load-use, then same with rd=x0
    cycle("lu",    1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0);
    idle("lu_post");
    check_val("lu_cnt", 32'(hif.stall_cycles), 32'd1);
    cycle("lu_x0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle("lu_rs1", 1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 32'h0, 1'b0, 1'b0);

    // Taken branch, no fetch wait
    cycle("br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h8000_0040, 1'b0, 1'b0);
    check_val("br_addr", hif.pc_redirect_addr, 32'h8000_0040);
    idle("br_post");

    // Branch during an in-flight fetch
    cycle("bf1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h8000_0100, 1'b1, 1'b0);
    cycle("bf2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0,         1'b1, 1'b0);
    cycle("bf3", 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 32'h0,         1'b1, 1'b0);
    cycle("bf_redir", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check_val("bf_addr", hif.pc_redirect_addr, 32'h8000_0100);
    idle("bf_post");

    // Memory wait dominates load-use and branch
    for (int i = 0; i < 4; i++)
      cycle("mw", 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 32'h8000_0080, 1'b0, 1'b1);
    cycle("mw_redir", 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 32'h8000_0080, 1'b0, 1'b0);
    idle("mw_post");

    // Memory wait inside DISCARD
    cycle("dm_enter", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h8000_0200, 1'b1, 1'b0);
    cycle("dm_mem1",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle("dm_mem2",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle("dm_redir", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_val("dm_addr", hif.pc_redirect_addr, 32'h8000_0200);
    idle("dm_post");

    // Reset while draining: pending redirect must be dropped
    cycle("rd_enter", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h8000_0300, 1'b1, 1'b0);
    cycle("rd_wait",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    apply_reset("rd_reset");
    idle("rd_post");
    check_val("rd_noredir", 32'(hif.pc_redirect), 32'd0);

    // Counter saturation
    for (int i = 0; i < 20; i++)
      cycle("sat", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle("sat_post");
    check_val("sat_cnt", 32'(hif.stall_cycles), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
